de_pipe_reg: RTL and testbench
==============================

// Module: de_pipe_reg
// PURPOSE
//   D->E pipeline register of the 5-stage MIPS core. Captures decode-stage results
//   (instruction, PC, GRF read data, 32-bit extended immediate, destination register, Tnew)
//   on each clock edge and presents them to the E stage (ALU operand mux, forwarding).
//   Supports hold, and bubble insertion driven by the hazard unit. Loads Tnew already
//   aged by one stage for the E-stage hazard check.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC value placed in E_PC on reset and on a bubble
//   TNEW_W     2              width of Tnew field (stage-count until result ready)
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   reset      in   1       synchronous, active-high reset
//   en         in   1       1: load D-stage values; 0: hold current contents
//   clr        in   1       1: load a bubble (nop) on this edge
//   D_Instr    in   32      decoded instruction word
//   D_PC       in   32      PC of instruction in D
//   D_RD1      in   32      forwarded rs data
//   D_RD2      in   32      forwarded rt data
//   D_Imm32    in   32      extended immediate from the D-stage extender
//   D_A3       in   5       destination register number (0 if no write)
//   D_RegWrite in   1       instruction writes GRF
//   D_Tnew     in   TNEW_W  cycles (from D) until result available
//   E_Instr    out  32      registered instruction
//   E_PC       out  32      registered PC
//   E_RD1      out  32      registered rs data
//   E_RD2      out  32      registered rt data
//   E_Imm32    out  32      registered extended immediate
//   E_A3       out  5       registered destination register
//   E_RegWrite out  1       registered write enable
//   E_Tnew     out  TNEW_W  Tnew as seen in E
//   E_Valid    out  1       1: E holds a real instruction; 0: bubble
// BEHAVIOUR
//   - Priority per rising edge: reset > clr > !en (hold) > load.
//   - reset or clr: E_Instr=0 (sll $0 nop), E_PC=RESET_PC, E_RD1=E_RD2=E_Imm32=0,
//     E_A3=0, E_RegWrite=0, E_Tnew=0, E_Valid=0. Identical bubble state for both.
//   - clr with en=0 in the same cycle: bubble wins (hazard stall inserts bubble).
//   - hold (en=0, clr=0): every output keeps its value, including E_Tnew (no aging).
//   - load (en=1, clr=0): all data fields copy D inputs; E_Valid=1.
//       E_A3       <= D_RegWrite ? D_A3 : 5'd0
//       E_RegWrite <= D_RegWrite & (D_A3 != 0)
//       E_Tnew     <= (D_Tnew == 0) ? 0 : D_Tnew - 1   (saturating, never wraps)
//   - Latency: exactly one cycle D->E; no combinational path from any input to any output.
//   - No state machine beyond the valid bit; E_Valid is a pure function of the last
//     update kind (load=1, bubble/reset=0, hold=unchanged).
//   - reset mid-stream discards the held instruction; the first post-reset load is
//     the instruction presented on D in that cycle.
// TESTING
//   1 reset=1 one edge, any D inputs -> all outputs per bubble state, E_PC=32'h3000, E_Valid=0.
//   2 en=1 clr=0, D_Instr=32'h3422_0010 (ori), D_Imm32=32'h0000_0010, D_A3=2, D_RegWrite=1,
//     D_Tnew=2 -> next cycle E_Instr/E_Imm32 match, E_A3=2, E_Tnew=1, E_Valid=1.
//   3 load D_Tnew=0 -> E_Tnew=0 (no wrap to 3); D_A3=0 with D_RegWrite=1 -> E_RegWrite=0.
//   4 load, then en=0 for 3 cycles with changing D -> outputs frozen incl. E_Tnew; then en=1 loads new.
//   5 clr=1 and en=0 same edge after valid load -> bubble (E_Instr=0, E_A3=0, E_Valid=0).
//   6 D_RegWrite=0, D_A3=5'd31 -> E_A3=0, E_RegWrite=0; reset asserted with clr=0 en=1 -> bubble.

Source files
------------

// File: rtl/de_pipe_reg_if.sv
// D->E pipeline register bus: D-stage results and hazard controls in, E-stage view out.
interface de_pipe_reg_if #(
  parameter int unsigned TNEW_W = 2
);
  logic              en;
  logic              clr;
  logic [31:0]       D_Instr;
  logic [31:0]       D_PC;
  logic [31:0]       D_RD1;
  logic [31:0]       D_RD2;
  logic [31:0]       D_Imm32;
  logic [4:0]        D_A3;
  logic              D_RegWrite;
  logic [TNEW_W-1:0] D_Tnew;
  logic [31:0]       E_Instr;
  logic [31:0]       E_PC;
  logic [31:0]       E_RD1;
  logic [31:0]       E_RD2;
  logic [31:0]       E_Imm32;
  logic [4:0]        E_A3;
  logic              E_RegWrite;
  logic [TNEW_W-1:0] E_Tnew;
  logic              E_Valid;

  modport master (
    output en, clr, D_Instr, D_PC, D_RD1, D_RD2, D_Imm32, D_A3, D_RegWrite, D_Tnew,
    input  E_Instr, E_PC, E_RD1, E_RD2, E_Imm32, E_A3, E_RegWrite, E_Tnew, E_Valid
  );

  modport slave (
    input  en, clr, D_Instr, D_PC, D_RD1, D_RD2, D_Imm32, D_A3, D_RegWrite, D_Tnew,
    output E_Instr, E_PC, E_RD1, E_RD2, E_Imm32, E_A3, E_RegWrite, E_Tnew, E_Valid
  );
endinterface

// File: rtl/de_pipe_reg.sv
// D->E pipeline register of the 5-stage MIPS core with hold, bubble insertion
// and one-stage Tnew aging on load.
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TNEW_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  de_pipe_reg_if.slave     bus
);

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      // Reset and hazard bubble share one state: an sll $0 nop that writes nothing.
      bus.E_Instr    <= '0;
      bus.E_PC       <= RESET_PC;
      bus.E_RD1      <= '0;
      bus.E_RD2      <= '0;
      bus.E_Imm32    <= '0;
      bus.E_A3       <= '0;
      bus.E_RegWrite <= 1'b0;
      bus.E_Tnew     <= '0;
      bus.E_Valid    <= 1'b0;
    end else if (bus.en) begin
      bus.E_Instr    <= bus.D_Instr;
      bus.E_PC       <= bus.D_PC;
      bus.E_RD1      <= bus.D_RD1;
      bus.E_RD2      <= bus.D_RD2;
      bus.E_Imm32    <= bus.D_Imm32;
      bus.E_A3       <= bus.D_RegWrite ? bus.D_A3 : 5'd0;
      bus.E_RegWrite <= bus.D_RegWrite && (bus.D_A3 != 5'd0);
      // Saturating decrement so a ready result never wraps back to "far away".
      bus.E_Tnew     <= (bus.D_Tnew == '0) ? '0 : bus.D_Tnew - TNEW_W'(1);
      bus.E_Valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed and randomized checks of de_pipe_reg against a reference model.
module tb_de_pipe_reg;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  de_pipe_reg_if #(.TNEW_W(2)) bus ();

  de_pipe_reg #(.RESET_PC(RPC), .TNEW_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected E-stage contents
  logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_a3;
  logic        m_rw, m_valid;
  int          m_tnew;

  task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s got=%h exp=%h", tag, fld, got, exp);
    end
  endtask

  task automatic chk(input string tag);
    cmp(tag, "E_Instr",    bus.E_Instr,                m_instr);
    cmp(tag, "E_PC",       bus.E_PC,                   m_pc);
    cmp(tag, "E_RD1",      bus.E_RD1,                  m_rd1);
    cmp(tag, "E_RD2",      bus.E_RD2,                  m_rd2);
    cmp(tag, "E_Imm32",    bus.E_Imm32,                m_imm);
    cmp(tag, "E_A3",       {27'd0, bus.E_A3},          {27'd0, m_a3});
    cmp(tag, "E_RegWrite", {31'd0, bus.E_RegWrite},    {31'd0, m_rw});
    cmp(tag, "E_Tnew",     {30'd0, bus.E_Tnew},        32'(m_tnew));
    cmp(tag, "E_Valid",    {31'd0, bus.E_Valid},       {31'd0, m_valid});
  endtask

  task automatic make_bubble();
    m_instr = 32'd0; m_pc = RPC; m_rd1 = 32'd0; m_rd2 = 32'd0; m_imm = 32'd0;
    m_a3 = 5'd0; m_rw = 1'b0; m_tnew = 0; m_valid = 1'b0;
  endtask

  // Apply one clock edge: predict from the current inputs, then check after the edge.
  task automatic step(input string tag);
    if (reset || bus.clr) make_bubble();
    else if (bus.en) begin
      m_instr = bus.D_Instr; m_pc = bus.D_PC; m_rd1 = bus.D_RD1; m_rd2 = bus.D_RD2;
      m_imm = bus.D_Imm32;
      if (bus.D_RegWrite && bus.D_A3 != 0) begin m_a3 = bus.D_A3; m_rw = 1'b1; end
      else if (bus.D_RegWrite) begin m_a3 = 5'd0; m_rw = 1'b0; end
      else begin m_a3 = 5'd0; m_rw = 1'b0; end
      m_tnew = (int'(bus.D_Tnew) > 0) ? int'(bus.D_Tnew) - 1 : 0;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic rand_d();
    bus.D_Instr = $urandom; bus.D_PC = $urandom; bus.D_RD1 = $urandom;
    bus.D_RD2 = $urandom; bus.D_Imm32 = $urandom;
    bus.D_A3 = 5'($urandom); bus.D_RegWrite = 1'($urandom);
    bus.D_Tnew = 2'($urandom_range(0, 3));
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b1; bus.clr = 1'b0;
    rand_d();
    @(negedge clk);

    // 1: reset gives bubble state
    step("reset");
    cmp("reset_pc", "E_PC", bus.E_PC, 32'h0000_3000);
    reset = 1'b0;

    // 2: ori load, Tnew aged 2->1
    bus.D_Instr = 32'h3422_0010; bus.D_Imm32 = 32'h0000_0010; bus.D_A3 = 5'd2;
    bus.D_RegWrite = 1'b1; bus.D_Tnew = 2'd2; bus.D_PC = 32'h0000_3004;
    step("ori_load");
    cmp("ori_tnew", "E_Tnew", {30'd0, bus.E_Tnew}, 32'd1);

    // 3: Tnew 0 saturates; A3=0 suppresses write
    bus.D_Tnew = 2'd0; bus.D_A3 = 5'd0; bus.D_RegWrite = 1'b1;
    step("tnew0_a3zero");

    // 4: load then hold three cycles with changing D
    rand_d(); bus.D_Tnew = 2'd3; bus.D_RegWrite = 1'b1; bus.D_A3 = 5'd7;
    step("pre_hold");
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step("hold");
    end
    bus.en = 1'b1; rand_d();
    step("after_hold");

    // 5: clr with en=0 gives bubble
    bus.en = 1'b0; bus.clr = 1'b1; rand_d();
    step("clr_stall");
    bus.clr = 1'b0; bus.en = 1'b1;

    // 6: no write with A3=31; then reset mid-stream
    rand_d(); bus.D_RegWrite = 1'b0; bus.D_A3 = 5'd31;
    step("nowrite_a3_31");
    rand_d(); bus.D_RegWrite = 1'b1; bus.D_A3 = 5'd9;
    step("load_before_reset");
    reset = 1'b1; rand_d();
    step("reset_midstream");
    reset = 1'b0; rand_d();
    step("first_post_reset");

    // Randomized mix of load / hold / bubble / reset
    for (int i = 0; i < 300; i++) begin
      rand_d();
      bus.en  = ($urandom_range(0, 3) != 0);
      bus.clr = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 19) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
